// File: rtl/network_controller_pkg.sv
// Shared constants for the neuron controller: FSM encoding, Q8.8 limits and
// the {weight, input} field positions inside a 32-bit ROM word.
package network_controller_pkg;

  localparam int DEF_NUM_UNITS = 4;
  localparam int DEF_ADDR_W    = 2;
  localparam int Q_FRAC_W      = 8;

  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;

  localparam int W_MSB = 31;
  localparam int W_LSB = 16;
  localparam int X_MSB = 15;
  localparam int X_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    ACT  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/network_controller_sat_q88.sv
// Combinational scale-and-saturate from a wide signed accumulator to Q8.8.
// Define NETWORK_CONTROLLER_RELU_EN to clamp negative results to zero.
module sat_q88
  import network_controller_pkg::*;
#(
  parameter int ACC_W  = 35,
  parameter int FRAC_W = Q_FRAC_W
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [15:0]      q_o
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-32768);

  logic signed [ACC_W-1:0] scaled;

  assign scaled = acc_i >>> FRAC_W;

  always_comb begin
    q_o = scaled[15:0];
    if (scaled > MAX_V) begin
      q_o = Q_MAX;
    end else if (scaled < MIN_V) begin
      q_o = Q_MIN;
    end
`ifdef NETWORK_CONTROLLER_RELU_EN
    if (q_o[15]) begin
      q_o = 16'h0000;
    end
`endif
  end

endmodule

// File: rtl/network_controller.sv
// Single-neuron controller: captures {weight, input} words, runs a serial MAC,
// then saturates to Q8.8. Optional ReLU via NETWORK_CONTROLLER_RELU_EN.
module network_controller
  import network_controller_pkg::*;
#(
  parameter int NUM_UNITS = DEF_NUM_UNITS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FRAC_W    = Q_FRAC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       data_in,
  input  logic [ADDR_W-1:0] address,
  input  logic              writeData,
  input  logic              start,
  output logic              busy,
  output logic [15:0]       result,
  output logic              result_valid
);

  // Wide enough that NUM_UNITS full-scale products can never overflow.
  localparam int ACC_W = 32 + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_UNITS - 1);

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]             result_q, result_d;
  logic [31:0]             regs_q [NUM_UNITS];
  logic [31:0]             regs_d [NUM_UNITS];

  logic signed [15:0] weight;
  logic signed [15:0] in_val;
  logic signed [31:0] product;
  logic [15:0]        sat_out;

  assign weight  = regs_q[idx_q][W_MSB:W_LSB];
  assign in_val  = regs_q[idx_q][X_MSB:X_LSB];
  assign product = weight * in_val;

  sat_q88 #(
    .ACC_W  (ACC_W),
    .FRAC_W (FRAC_W)
  ) u_sat (
    .acc_i (acc_q),
    .q_o   (sat_out)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    regs_d   = regs_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        acc_d = '0;
        if (writeData) begin
          regs_d[address] = data_in;
        end
        if (start) begin
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + {{(ACC_W-32){product[31]}}, product};
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ACT;
        end
      end
      ACT: begin
        result_d = sat_out;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      regs_q   <= regs_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;

endmodule
